merge4_rr_arbiter: RTL

Synchronous round-robin scheduler that feeds a 4-input mutex merge stage. The merge stage requires its four drive inputs to be mutually exclusive. This block guarantees that by granting exactly one requester at a time. It issues a single drive pulse for the winner and holds the grant until the merge returns its free/acknowledge. It also provides starvation-free rotation and a watchdog timeout on a free that never returns.

---
 rtl/merge4_rr_arbiter.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/merge4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// merge4_rr_arbiter
//
// Round-robin scheduler in front of a 4-input mutex merge stage. The merge
// needs its drive inputs to be mutually exclusive, so exactly one requester
// is granted at a time. The winner gets a single drive pulse, and the grant
// is held until the merge returns its (asynchronous) free/acknowledge. A
// watchdog aborts a grant whose free never comes back.
//
// Ports
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset
//   i_req[3:0]    requests, rising-edge sensitive (level-tolerant)
//   o_grant[3:0]  one-hot grant, held from the drive cycle through the wait
//   o_drive[3:0]  one-cycle drive pulse to the merge input of the winner
//   i_free        free/ack from the merge, asynchronous to clk
//   o_done[3:0]   one-cycle completion pulse to the served requester
//   o_busy        high whenever the scheduler is not idle
//   o_timeout     sticky watchdog flag
//   o_timeout_id  requester aborted by the most recent timeout
//
// Every output is a flop; next-state values are computed from the next FSM
// state so that the registered outputs line up with the state they describe.
// -----------------------------------------------------------------------------
module merge4_rr_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_req,
  output logic [3:0] o_grant,
  output logic [3:0] o_drive,
  input  logic       i_free,
  output logic [3:0] o_done,
  output logic       o_busy,
  output logic       o_timeout,
  output logic [1:0] o_timeout_id
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A synchronizer shorter than two flops is not a synchronizer.
  localparam int              SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic            TO_EN   = (TIMEOUT != 0);
  // Counter value on the last WAIT cycle before the watchdog fires: the
  // counter is cleared in DRIVE and advances once per WAIT edge.
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT != 0) ? TO_W'(TIMEOUT - 1) : '0;

  // Priority search starting at ptr and wrapping around mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Architectural state
  state_t            state_r;
  logic [3:0]        req_q_r;
  logic [3:0]        pending_r;
  logic [1:0]        ptr_r;
  logic [1:0]        win_r;
  logic [TO_W-1:0]   cnt_r;
  logic [SYNC_N-1:0] sync_r;
  logic              free_d_r;
  logic              free_rise_r;

  // Output flops
  logic [3:0]        grant_r;
  logic [3:0]        drive_r;
  logic [3:0]        done_r;
  logic              busy_r;
  logic              timeout_r;
  logic [1:0]        timeout_id_r;

  // Next-state values
  state_t            state_s;
  logic [1:0]        win_s;
  logic              take_s;
  logic              to_fire_s;
  logic [3:0]        pending_s;
  logic [TO_W-1:0]   cnt_s;
  logic [1:0]        ptr_s;
  logic [3:0]        grant_s;
  logic [3:0]        drive_s;
  logic [3:0]        done_s;
  logic              busy_s;
  logic              timeout_s;
  logic [1:0]        timeout_id_s;
  logic              free_edge_s;

  // Rising edge of the synchronized free, registered before the FSM uses it.
  assign free_edge_s = sync_r[SYNC_N-1] & ~free_d_r;

  // FSM next-state: arbitration in IDLE, free/watchdog resolution in WAIT.
  always_comb begin
    state_s   = state_r;
    win_s     = win_r;
    take_s    = 1'b0;
    to_fire_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|pending_r) begin
          win_s   = rr_pick(pending_r, ptr_r);
          take_s  = 1'b1;
          state_s = ST_DRIVE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        // A free that arrives on the very cycle the watchdog would fire
        // counts as a normal completion.
        if (free_rise_r) begin
          state_s = ST_DONE;
        end else if (TO_EN && (cnt_r == TO_LAST)) begin
          to_fire_s = 1'b1;
          state_s   = ST_DONE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: pending set/clear, watchdog counter, pointer.
  always_comb begin
    pending_s = pending_r;
    cnt_s     = cnt_r;
    ptr_s     = ptr_r;
    // A new edge on the winner in the same cycle survives the clear.
    if (take_s) begin
      pending_s = pending_r & ~onehot4(win_s);
    end else begin
      pending_s = pending_r;
    end
    pending_s = pending_s | (i_req & ~req_q_r);
    case (state_r)
      ST_DRIVE: cnt_s = '0;
      ST_WAIT:  cnt_s = cnt_r + 1'b1;
      ST_DONE:  ptr_s = win_r + 2'd1;
      default:  cnt_s = cnt_r;
    endcase
  end

  // Output next values, derived from the state the FSM is about to enter.
  always_comb begin
    grant_s      = 4'b0000;
    drive_s      = 4'b0000;
    done_s       = 4'b0000;
    busy_s       = (state_s != ST_IDLE);
    timeout_s    = timeout_r | to_fire_s;
    timeout_id_s = timeout_id_r;
    case (state_s)
      ST_DRIVE: begin
        grant_s = onehot4(win_s);
        drive_s = onehot4(win_s);
      end
      ST_WAIT: begin
        grant_s = onehot4(win_s);
      end
      ST_DONE: begin
        done_s = onehot4(win_s);
      end
      default: begin
        grant_s = 4'b0000;
      end
    endcase
    if (to_fire_s) begin
      timeout_id_s = win_r;
    end else begin
      timeout_id_s = timeout_id_r;
    end
  end

  // FSM, request capture and watchdog state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      req_q_r   <= 4'b0000;
      pending_r <= 4'b0000;
      ptr_r     <= 2'd0;
      win_r     <= 2'd0;
      cnt_r     <= '0;
    end else begin
      state_r   <= state_s;
      req_q_r   <= i_req;
      pending_r <= pending_s;
      ptr_r     <= ptr_s;
      win_r     <= win_s;
      cnt_r     <= cnt_s;
    end
  end

  // Free synchronizer chain plus the edge-detect flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r      <= '0;
      free_d_r    <= 1'b0;
      free_rise_r <= 1'b0;
    end else begin
      sync_r      <= {sync_r[SYNC_N-2:0], i_free};
      free_d_r    <= sync_r[SYNC_N-1];
      free_rise_r <= free_edge_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r      <= 4'b0000;
      drive_r      <= 4'b0000;
      done_r       <= 4'b0000;
      busy_r       <= 1'b0;
      timeout_r    <= 1'b0;
      timeout_id_r <= 2'd0;
    end else begin
      grant_r      <= grant_s;
      drive_r      <= drive_s;
      done_r       <= done_s;
      busy_r       <= busy_s;
      timeout_r    <= timeout_s;
      timeout_id_r <= timeout_id_s;
    end
  end

  assign o_grant      = grant_r;
  assign o_drive      = drive_r;
  assign o_done       = done_r;
  assign o_busy       = busy_r;
  assign o_timeout    = timeout_r;
  assign o_timeout_id = timeout_id_r;

endmodule
